// File: rtl/mdio_mgmt_slave.sv
// PHY-side MDIO management frame receiver/responder: it decodes write and read frames and
// drives turnaround and read data back to the master. Field widths and preamble length are parametrised.
module mdio_mgmt_slave #(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 5,
  parameter int PRE_LEN  = 32,
  parameter int BCAST_EN = 1
) (
  input  logic              MDC,
  input  logic              reset,
  input  logic              MDIO_OUT,
  input  logic              MDIO_OE,
  input  logic [4:0]        PHY_ADDR,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic              MDIO_IN,
  output logic              MDIO_IN_OE,
  output logic [REG_AW-1:0] ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              WR_STB,
  output logic              RD_STB,
  output logic              MDIO_DONE,
  output logic              FRAME_ERR,
  output logic              BUSY
);

  localparam int FMAX  = (DATA_W > REG_AW) ? DATA_W : REG_AW;
  localparam int SH_W  = (FMAX > 5) ? FMAX : 5;
  localparam int CNT_W = $clog2(SH_W) + 1;
  localparam int PC_W  = $clog2(PRE_LEN + 2);

  typedef enum logic [3:0] {
    IDLE, ST2, OP, PHYAD, REGAD, TA_W, WDATA, TA_R, RDATA, RDONE
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SH_W-2:0]   sh_q, sh_d;
  logic [SH_W-1:0]   sh_next;
  logic              op_rd_q, op_rd_d;
  logic [DATA_W-1:0] rd_sr_q, rd_sr_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              mdio_in_q, mdio_in_d;
  logic              mdio_in_oe_q, mdio_in_oe_d;
  logic              wr_stb_q, wr_stb_d;
  logic              rd_stb_q, rd_stb_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              phy_hit;
  logic              master_state;

  // One shared shift register collects every master-driven field; the low bits hold the field just completed.
  assign sh_next      = {sh_q, MDIO_OUT};
  assign phy_hit      = (sh_next[4:0] == PHY_ADDR) || ((BCAST_EN != 0) && (sh_next[4:0] == 5'd0));
  assign master_state = state_q inside {ST2, OP, PHYAD, REGAD, TA_W, WDATA};

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    bit_cnt_d    = bit_cnt_q + CNT_W'(1);
    sh_d         = sh_next[SH_W-2:0];
    op_rd_d      = op_rd_q;
    rd_sr_d      = rd_sr_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    mdio_in_d    = mdio_in_q;
    mdio_in_oe_d = mdio_in_oe_q;
    wr_stb_d     = 1'b0;
    rd_stb_d     = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (!MDIO_OE) begin
          pre_cnt_d = '0;
        end else if (MDIO_OUT) begin
          if (pre_cnt_q != PC_W'(PRE_LEN)) pre_cnt_d = pre_cnt_q + PC_W'(1);
        end else begin
          pre_cnt_d = '0;
          if (pre_cnt_q == PC_W'(PRE_LEN)) state_d = ST2;
        end
      end
      ST2: begin
        bit_cnt_d = '0;
        if (MDIO_OUT) state_d = OP;
        else begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      OP: begin
        if (bit_cnt_q != '0) begin
          bit_cnt_d = '0;
          case ({sh_q[0], MDIO_OUT})
            2'b01: begin op_rd_d = 1'b0; state_d = PHYAD; end
            2'b10: begin op_rd_d = 1'b1; state_d = PHYAD; end
            default: begin state_d = IDLE; err_d = 1'b1; end
          endcase
        end
      end
      PHYAD: begin
        if (bit_cnt_q == CNT_W'(4)) begin
          bit_cnt_d = '0;
          state_d   = phy_hit ? REGAD : IDLE;
        end
      end
      REGAD: begin
        if (bit_cnt_q == CNT_W'(REG_AW - 1)) begin
          bit_cnt_d = '0;
          addr_d    = sh_next[REG_AW-1:0];
          rd_stb_d  = op_rd_q;
          state_d   = op_rd_q ? TA_R : TA_W;
        end
      end
      TA_W: begin
        if (bit_cnt_q == '0) begin
          if (!MDIO_OUT) begin state_d = IDLE; err_d = 1'b1; end
        end else begin
          bit_cnt_d = '0;
          if (MDIO_OUT) begin state_d = IDLE; err_d = 1'b1; end
          else state_d = WDATA;
        end
      end
      WDATA: begin
        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
          wr_data_d = sh_next[DATA_W-1:0];
          wr_stb_d  = 1'b1;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      TA_R: begin
        bit_cnt_d    = '0;
        rd_sr_d      = RD_DATA;
        mdio_in_oe_d = 1'b1;
        mdio_in_d    = 1'b0;
        state_d      = RDATA;
      end
      RDATA: begin
        mdio_in_d = rd_sr_q[DATA_W-1];
        rd_sr_d   = rd_sr_q << 1;
        if (bit_cnt_q == CNT_W'(DATA_W - 1)) state_d = RDONE;
      end
      RDONE: begin
        mdio_in_oe_d = 1'b0;
        mdio_in_d    = 1'b0;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Master let go of the line mid-frame: abort without touching the register-file side.
    if (master_state && !MDIO_OE) begin
      state_d   = IDLE;
      err_d     = 1'b1;
      wr_stb_d  = 1'b0;
      rd_stb_d  = 1'b0;
      done_d    = 1'b0;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
    end
  end

  always_ff @(posedge MDC or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pre_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      sh_q         <= '0;
      op_rd_q      <= 1'b0;
      rd_sr_q      <= '0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      mdio_in_q    <= 1'b0;
      mdio_in_oe_q <= 1'b0;
      wr_stb_q     <= 1'b0;
      rd_stb_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sh_q         <= sh_d;
      op_rd_q      <= op_rd_d;
      rd_sr_q      <= rd_sr_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      mdio_in_q    <= mdio_in_d;
      mdio_in_oe_q <= mdio_in_oe_d;
      wr_stb_q     <= wr_stb_d;
      rd_stb_q     <= rd_stb_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign MDIO_IN    = mdio_in_q;
  assign MDIO_IN_OE = mdio_in_oe_q;
  assign ADDR       = addr_q;
  assign WR_DATA    = wr_data_q;
  assign WR_STB     = wr_stb_q;
  assign RD_STB     = rd_stb_q;
  assign MDIO_DONE  = done_q;
  assign FRAME_ERR  = err_q;
  assign BUSY       = (state_q != IDLE);

endmodule
